// File: rtl/obc_bitserial_ctrl.sv
// obc_bitserial_ctrl: bit-serial offset-binary-coding DFT bin controller driving an external ROM bank.
// Optional OBC_OFFSET_EN adds offset_in and a FINAL state that adds the initial-condition term.
module obc_bitserial_ctrl #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [16*DATA_W-1:0]     samples_in,
    output logic [15:0]              rom_bits,
    input  logic signed [ACC_W-1:0]  rom_sum,
`ifdef OBC_OFFSET_EN
    input  logic signed [ACC_W-1:0]  offset_in,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  result,
    output logic                     busy
);
    localparam int KW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(DATA_W - 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
`ifdef OBC_OFFSET_EN
    localparam logic [1:0] FINAL = 2'd3;
`endif

    logic [1:0]                state_q, state_d;
    logic [KW-1:0]             k_q, k_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d, res_q, res_d, acc_nx, p;
    logic [15:0][DATA_W-1:0]   smp_q, smp_d;
    logic                      last;

    assign last     = k_q == K_LAST;
    // The MSB plane carries negative weight in two's complement, hence the subtraction.
    assign p        = last ? -rom_sum : rom_sum;
    assign acc_nx   = ((k_q == '0) ? '0 : (acc_q >>> 1)) + p;
    assign in_ready = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy     = state_q != IDLE;
    assign result   = res_q;

    always_comb begin
        rom_bits = '0;
        for (int i = 0; i < 16; i++)
            rom_bits[i] = (state_q == RUN) && smp_q[i][k_q];
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        res_d   = res_q;
        smp_d   = smp_q;
        if (state_q == IDLE && in_valid) begin
            smp_d   = samples_in;
            k_d     = '0;
            state_d = RUN;
        end else if (state_q == RUN) begin
            acc_d = acc_nx;
            k_d   = last ? '0 : k_q + 1'b1;
`ifdef OBC_OFFSET_EN
            state_d = last ? FINAL : RUN;
`else
            state_d = last ? DONE : RUN;
            res_d   = last ? acc_nx : res_q;
`endif
        end
`ifdef OBC_OFFSET_EN
        else if (state_q == FINAL) begin
            res_d   = acc_q + offset_in;
            state_d = DONE;
        end
`endif
        else if (state_q == DONE && out_ready)
            state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            smp_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            smp_q   <= smp_d;
        end
    end
endmodule

// File: tb/tb_obc_bitserial_ctrl.sv
// tb_obc_bitserial_ctrl: directed checks of obc_bitserial_ctrl at DATA_W=4 with a bench-side ROM model.
module tb_obc_bitserial_ctrl;
`ifdef OBC_OFFSET_EN
    localparam int LAT = 6;
    localparam logic [31:0] OFF = 32'd10;
`else
    localparam int LAT = 5;
    localparam logic [31:0] OFF = 32'd0;
`endif
    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [63:0] samples_in = '0;
    logic [15:0] rom_bits;
    logic [31:0] rom_sum;
    logic        out_valid;
    logic        out_ready = 0;
    logic [31:0] result;
    logic        busy;
    logic        use_const = 1;
    int          n = 0;
    int          errs = 0;
`ifdef OBC_OFFSET_EN
    logic [31:0] offset_in = 32'd10;
`endif

    always #5 clk = ~clk;
    // ROM model: either a constant 16, or 8 * rom_bits read as an unsigned number
    always_comb rom_sum = use_const ? 32'd16 : {13'b0, rom_bits, 3'b0};

    obc_bitserial_ctrl #(.DATA_W(4), .ACC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .samples_in(samples_in), .rom_bits(rom_bits), .rom_sum(rom_sum),
`ifdef OBC_OFFSET_EN
        .offset_in(offset_in),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_block(input string tag, input logic [63:0] s, input logic [15:0] b0, b1, b2, b3,
                             input logic [31:0] exp, input int stall);
        logic [15:0] eb[4];
        int lat;
        eb = '{b0, b1, b2, b3};
        chk({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
        samples_in = s;
        in_valid = 1;
        step();
        in_valid = 0;
        samples_in = ~s;
        lat = 1;
        chk({tag, ".busy"}, {31'b0, busy}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s.rom_bits%0d", tag, k), {16'b0, rom_bits}, {16'b0, eb[k]});
            step();
            lat++;
        end
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, ".latency"}, lat, LAT);
        chk({tag, ".result"}, result, exp + OFF);
        for (int c = 0; c < stall; c++) begin
            in_valid = 1;
            samples_in = 64'hFFFF_FFFF_FFFF_FFFF;
            step();
            chk($sformatf("%s.stall_ov%0d", tag, c), {31'b0, out_valid}, 32'd1);
            chk($sformatf("%s.stall_res%0d", tag, c), result, exp + OFF);
        end
        in_valid = 0;
        chk({tag, ".hs_in_ready"}, {31'b0, in_ready}, 32'd0);
        out_ready = 1;
        step();
        out_ready = 0;
        chk({tag, ".post_ov"}, {31'b0, out_valid}, 32'd0);
        chk({tag, ".post_in_ready"}, {31'b0, in_ready}, 32'd1);
        chk({tag, ".post_rom_bits"}, {16'b0, rom_bits}, 32'd0);
    endtask

    initial begin
        int ov_seen;
        #2;
        chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst.busy", {31'b0, busy}, 32'd0);
        chk("rst.rom_bits", {16'b0, rom_bits}, 32'd0);
        chk("rst.result", result, 32'd0);
        step();
        rst_n = 1;
        step();
        chk("rst.in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1;
        step();
        out_ready = 0;
        chk("idle_out_ready.busy", {31'b0, busy}, 32'd0);

        use_const = 1;
        run_block("const16", 64'h0, 16'h0, 16'h0, 16'h0, 16'h0, 32'hFFFF_FFFE, 0);
        use_const = 0;
        run_block("x0_5", 64'h5, 16'h1, 16'h0, 16'h1, 16'h0, 32'd5, 0);
        run_block("x0_5_x1_3", 64'h35, 16'h3, 16'h2, 16'h1, 16'h0, 32'd11, 0);
        run_block("x0_m5_stall", 64'hB, 16'h1, 16'h1, 16'h0, 16'h1, 32'hFFFF_FFFB, 5);
        run_block("x15_m8", 64'h8000_0000_0000_0000, 16'h0, 16'h0, 16'h0, 16'h8000, 32'hFFFC_0000, 0);

        samples_in = 64'h5;
        in_valid = 1;
        step();
        in_valid = 0;
        step();
        step();
        chk("midrst.k2_bits", {16'b0, rom_bits}, 32'h1);
        rst_n = 0;
        #1;
        chk("midrst.busy", {31'b0, busy}, 32'd0);
        chk("midrst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst.rom_bits", {16'b0, rom_bits}, 32'd0);
        chk("midrst.result", result, 32'd0);
        chk("midrst.in_ready", {31'b0, in_ready}, 32'd1);
        #2;
        rst_n = 1;
        ov_seen = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (out_valid) ov_seen++;
        end
        chk("midrst.no_output", ov_seen, 0);
        run_block("after_rst", 64'hB, 16'h1, 16'h1, 16'h0, 16'h1, 32'hFFFF_FFFB, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule

// File: doc/obc_bitserial_ctrl.md
OBC_BITSERIAL_CTRL -- requirements
Module: obc_bitserial_ctrl

Interface
REQ-001 Parameter DATA_W, default 16: sample width in bits, two's complement, 2..32.
REQ-002 Parameter ACC_W, default 32: accumulator, ROM-sum and result width.
REQ-003 Port clk  in  1: single clock, rising edge.
REQ-004 Port rst_n  in  1: reset, asynchronous, active-low.
REQ-005 Port in_valid  in  1: sample block offered.
REQ-006 Port in_ready  out  1: block accepted when in_valid&&in_ready; high only in IDLE.
REQ-007 Port samples_in  in  16*DATA_W: samples x0..x15; x[i] = samples_in[i*DATA_W +: DATA_W].
REQ-008 Port rom_bits  out  16: bit-plane to the OBC ROM bank; rom_bits[i] = current bit of x[i].
REQ-009 Port rom_sum  in  ACC_W: signed, combinational sum of the 8 ROM outputs for rom_bits.
REQ-010 Port out_valid  out  1: result valid.
REQ-011 Port out_ready  in  1: result consumed when out_valid&&out_ready.
REQ-012 Port result  out  ACC_W: signed DFT bin result.
REQ-013 Port busy  out  1: high in any state other than IDLE.

Function
REQ-014 FSM states IDLE, RUN, DONE; with OBC_OFFSET_EN also FINAL, between RUN and DONE.
REQ-015 IDLE->RUN on accept; samples latched into a 16xDATA_W register; bit counter k cleared to 0.
REQ-016 RUN: rom_bits presents bit k of every latched sample; k increments each cycle, 0..DATA_W-1.
REQ-017 RUN update per cycle: p = rom_sum if k<DATA_W-1, else -rom_sum; acc <= (k==0 ? 0 : acc>>>1) + p.
REQ-018 Shift is arithmetic (sign-preserving); add/subtract wrap modulo 2^ACC_W, no saturation.
REQ-019 After k=DATA_W-1: RUN->DONE (RUN->FINAL with macro); result <= acc.
REQ-020 Latency accept -> out_valid high: DATA_W+1 cycles (DATA_W+2 with macro).
REQ-021 DONE: out_valid=1, result stable until handshake; on out_valid&&out_ready -> IDLE.
REQ-022 in_valid while busy ignored; samples_in changes during RUN have no effect.
REQ-023 In the handshake cycle in DONE, in_ready=0; a new block is accepted no earlier than the next cycle.
REQ-024 rom_bits = 0 outside RUN.
REQ-025 out_ready with out_valid low has no effect.

Reset
REQ-026 rst_n low, asynchronously, at any time including mid-RUN: state IDLE, k=0, acc=0, result=0, latched samples=0.
REQ-027 Output values under reset: in_ready=1 after rst_n deasserts; out_valid=0, busy=0, rom_bits=0, result=0.
REQ-028 Partially accumulated results are discarded by reset; no output follows.

Configuration
REQ-029 Macro OBC_OFFSET_EN defined: adds input port offset_in (ACC_W, signed, OBC initial-condition term) and state FINAL; FINAL performs result <= acc + offset_in (wrapping) for one cycle, then DONE.
REQ-030 OBC_OFFSET_EN undefined: no offset_in port, no FINAL state; result <= acc directly.

Verification
REQ-031 DATA_W=4, macro off, rom_sum held at 16 -> acc 16,24,28,-2; result=32'hFFFFFFFE after 5 cycles.
REQ-032 DATA_W=4, x0=4'b0101, x1..x15=0 -> rom_bits sequence 16'h0001,16'h0000,16'h0001,16'h0000.
REQ-033 Macro on, DATA_W=4, rom_sum=16, offset_in=10 -> result=8, out_valid 6 cycles after accept.
REQ-034 out_ready held low for 5 cycles in DONE -> out_valid and result stable; in_valid pulses ignored; IDLE one cycle after out_ready.
REQ-035 rst_n asserted at k=2 of RUN -> immediate IDLE, out_valid never asserts; next block yields correct result.
